oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
Sprite-DMA initiator: the requester side of the bus arbiter's spr_req/spr_gnt channel. It snoops CPU-bus writes to $4014. On a hit it requests the bus and copies 256 bytes from CPU page {wdata,8'h00} into PPU OAM via repeated writes to $2004. It sits beside the PPU register file in the CPU clock domain, between the shared bus outputs and the arbiter's sprite port.

Parameters:
DMA_REG_ADDR, 16'h4014, bus address whose write triggers a transfer
OAM_DATA_ADDR, 16'h2004, destination address written once per byte
XFER_LEN, 256, bytes per transfer (1..256); byte counter is 8 bits

Ports:
i_clk  input  1  CPU clock; all state changes on the rising edge
i_rst  input  1  asynchronous, active-high reset
i_bus_addr  input  16  shared bus address (arbiter output)
i_bus_wn  input  1  shared bus direction; 0 = write
i_bus_wdata  input  8  shared bus write data
o_spr_req  output  1  bus request to arbiter, held for the whole transfer
i_spr_gnt  input  1  arbiter grant; access presented this cycle is executed when 1
o_spr_addr  output  16  address of the current DMA access
o_spr_wn  output  1  1 = read access, 0 = write access
o_spr_wdata  output  8  data for the OAM write
i_spr_rdata  input  8  read data, valid in the same cycle as a granted read
o_busy  output  1  high from trigger until the DONE state ends
o_done  output  1  one-cycle pulse at transfer completion

Behaviour:
- Reset (async, any state): state=IDLE, page=0, idx=0, data latch=0. Outputs: o_spr_req=0, o_spr_addr=16'h0000, o_spr_wn=1, o_spr_wdata=0, o_busy=0, o_done=0.
- All outputs are registered or decoded from state only; none is combinational from an input.
- IDLE: req=0, addr=0, wn=1. Trigger when i_bus_wn=0 and i_bus_addr==DMA_REG_ADDR. On that edge: page<=i_bus_wdata, idx<=0, go to RD. Triggers in any other state are ignored.
- RD: req=1, wn=1, addr={page,idx}. If gnt=1: latch i_spr_rdata, go to WR. If gnt=0: hold everything (stall).
- WR: req=1, wn=0, addr=OAM_DATA_ADDR, wdata=latch. If gnt=1 and idx==XFER_LEN-1, go to DONE. If gnt=1 otherwise, idx<=idx+1 and go to RD. If gnt=0: hold.
- DONE: req=0, done=1 for exactly one cycle, then go to IDLE.
- o_busy=1 in RD, WR and DONE.
- Latency: the first request is visible the cycle after the trigger edge. With gnt held at 1, a transfer is 2*XFER_LEN request cycles plus 1 DONE cycle. For the default that is 512 request cycles, with done in cycle 513 after the trigger.
- Address arithmetic: the low byte is idx and never carries into page. For page 8'hFF the last read is $FFFF with no wrap into $0000.
- A grant can drop at any point, for example when DMC preempts. The engine resumes the same access with no skip and no repeat.
- Self-writes to $2004 are never mistaken for triggers, because DMA_REG_ADDR differs from OAM_DATA_ADDR and triggers are only sampled in IDLE.
- A trigger in the same cycle as DONE is ignored.
- A reset during a transfer aborts it immediately. Partial OAM contents are left as written.

Test Plan:
- Write $4014=8'h02 with gnt tied to 1 -> reads $0200..$02FF alternate with writes to $2004 carrying the read data. Byte 0 is read in cycle 1 and written in cycle 2. done pulses in cycle 513; busy falls after it.
- Same transfer, gnt toggled in a pseudo-random 50% pattern -> the sequence of granted accesses is identical to the first test; no duplicate or missing bytes.
- Page 8'hFF -> last read address is $FFFF; req low after done; addr returns to $0000.
- Second $4014 write, and writes to $4015/$2004 by other masters, issued mid-transfer -> ignored; the original 256-byte sequence completes unchanged.
- Assert i_rst at byte 100 while in WR -> all outputs take reset values asynchronously. A new trigger then restarts cleanly at idx 0.
- XFER_LEN=4, page 8'h03 -> reads $0300..$0303 only; done pulses in cycle 9.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA initiator for the arbiter's sprite port.
// It watches shared-bus writes to DMA_REG_ADDR. On a hit it copies XFER_LEN bytes
// from CPU page {wdata,8'h00} into PPU OAM, as alternating reads and OAM_DATA_ADDR writes.
// Ports:
//   i_clk, i_rst                       CPU clock, async active-high reset
//   i_bus_addr/i_bus_wn/i_bus_wdata    snooped shared-bus access (trigger source)
//   o_spr_req, i_spr_gnt               request/grant handshake with the arbiter
//   o_spr_addr/o_spr_wn/o_spr_wdata    current DMA access
//   i_spr_rdata                        read data for a granted read
//   o_busy, o_done                     transfer in progress / one-cycle completion pulse
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    output logic        o_spr_req,
    input  logic        i_spr_gnt,
    output logic [15:0] o_spr_addr,
    output logic        o_spr_wn,
    output logic [7:0]  o_spr_wdata,
    input  logic [7:0]  i_spr_rdata,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned IDX_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       page;
    logic [7:0]       page_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       data;
    logic [7:0]       data_next;
    logic             trigger;

    // Any master writing the DMA register counts as a trigger.
    assign trigger = !i_bus_wn && (i_bus_addr == DMA_REG_ADDR);

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            page  <= '0;
            idx   <= '0;
            data  <= '0;
        end else begin
            state <= state_next;
            page  <= page_next;
            idx   <= idx_next;
            data  <= data_next;
        end
    end

    // Next state and state-decoded outputs.
    // A missing grant leaves every register unchanged, so a stalled access is simply re-presented.
    always_comb begin
        state_next  = state;
        page_next   = page;
        idx_next    = idx;
        data_next   = data;
        o_spr_req   = 1'b0;
        o_spr_addr  = 16'h0000;
        o_spr_wn    = 1'b1;
        o_spr_wdata = 8'h00;
        o_busy      = 1'b0;
        o_done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    page_next  = i_bus_wdata;
                    idx_next   = '0;
                    state_next = ST_RD;
                end
            end
            ST_RD: begin
                o_spr_req  = 1'b1;
                o_busy     = 1'b1;
                // Low byte is the index alone; it never carries into the page.
                o_spr_addr = {page, idx};
                if (i_spr_gnt) begin
                    data_next  = i_spr_rdata;
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                o_spr_req   = 1'b1;
                o_busy      = 1'b1;
                o_spr_wn    = 1'b0;
                o_spr_addr  = OAM_DATA_ADDR;
                o_spr_wdata = data;
                if (i_spr_gnt) begin
                    if (idx == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx + IDX_W'(1);
                        state_next = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                o_busy     = 1'b1;
                o_done     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_addr;
    logic        bus_wn;
    logic [7:0]  bus_wdata;
    logic        gnt;

    logic        spr_req,  spr_wn,  busy,  done;
    logic [15:0] spr_addr;
    logic [7:0]  spr_wdata, spr_rdata;
    logic        spr_req4, spr_wn4, busy4, done4;
    logic [15:0] spr_addr4;
    logic [7:0]  spr_wdata4, spr_rdata4;

    logic [7:0]  mem [0:65535];

    typedef struct packed {
        logic [15:0] addr;
        logic        wn;
        logic [7:0]  wdata;
    } acc_t;

    acc_t acc_q[$];
    acc_t acc4_q[$];
    acc_t exp_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // CPU memory answers reads combinationally for the addressed byte.
    assign spr_rdata  = mem[spr_addr];
    assign spr_rdata4 = mem[spr_addr4];

    oam_dma_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_bus_addr(bus_addr), .i_bus_wn(bus_wn), .i_bus_wdata(bus_wdata),
        .o_spr_req(spr_req), .i_spr_gnt(gnt),
        .o_spr_addr(spr_addr), .o_spr_wn(spr_wn), .o_spr_wdata(spr_wdata),
        .i_spr_rdata(spr_rdata), .o_busy(busy), .o_done(done)
    );

    oam_dma_ctrl #(.XFER_LEN(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_bus_addr(bus_addr), .i_bus_wn(bus_wn), .i_bus_wdata(bus_wdata),
        .o_spr_req(spr_req4), .i_spr_gnt(gnt),
        .o_spr_addr(spr_addr4), .o_spr_wn(spr_wn4), .o_spr_wdata(spr_wdata4),
        .i_spr_rdata(spr_rdata4), .o_busy(busy4), .o_done(done4)
    );

    // Record every executed (requested and granted) access; write data only matters for writes.
    always @(negedge clk) begin
        if (!rst) begin
            if (spr_req && gnt)
                acc_q.push_back(acc_t'{addr: spr_addr, wn: spr_wn, wdata: spr_wn ? 8'h00 : spr_wdata});
            if (spr_req4 && gnt)
                acc4_q.push_back(acc_t'{addr: spr_addr4, wn: spr_wn4, wdata: spr_wn4 ? 8'h00 : spr_wdata4});
        end
    end

    // Reference: n bytes, each a read of {page,k} then a write of that byte to $2004.
    function automatic void build_exp(input logic [7:0] p, input int n);
        logic [15:0] a;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            a = {p, 8'(k)};
            exp_q.push_back(acc_t'{addr: a, wn: 1'b1, wdata: 8'h00});
            exp_q.push_back(acc_t'{addr: 16'h2004, wn: 1'b0, wdata: mem[a]});
        end
    endfunction

    // One-cycle CPU write to $4014; returns at #1 into the first cycle after the trigger edge.
    task automatic trigger_dma(input logic [7:0] p);
        @(posedge clk); #1;
        bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = p;
        @(posedge clk); #1;
        bus_wn = 1'b1; bus_addr = 16'h0000;
    endtask

    // Drive grants cycle by cycle until done; optionally inject foreign bus writes.
    task automatic run_xfer(input int start_c, input bit rand_gnt, input bit inject,
                            input int max_c, output int done_c);
        done_c = 0;
        for (int c = start_c; c <= max_c && done_c == 0; c++) begin
            gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && (c == 101 || c == 201 || c == 301)) begin
                bus_wn    = 1'b0;
                bus_addr  = (c == 101) ? 16'h4014 : (c == 201) ? 16'h4015 : 16'h2004;
                bus_wdata = 8'h55;
            end else begin
                bus_wn = 1'b1;
            end
            @(negedge clk);
            if (done) done_c = c;
            @(posedge clk); #1;
        end
        bus_wn = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (spr_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", spr_req); end
        checks++; if (spr_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", spr_addr); end
        checks++; if (spr_wn !== 1'b1) begin errors++; $display("FAIL reset_wn got=%b exp=1", spr_wn); end
        checks++; if (spr_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%h exp=00", spr_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (spr_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset req=%b busy=%b exp=0/0", spr_req, busy); end
    endtask

    task automatic test_basic;
        int dc;
        acc_q.delete();
        trigger_dma(8'h02);
        gnt = 1'b1;
        @(negedge clk);
        checks++; if (spr_req !== 1'b1 || spr_wn !== 1'b1 || spr_addr !== 16'h0200 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_cycle1 req=%b wn=%b addr=%h busy=%b exp=1/1/0200/1", spr_req, spr_wn, spr_addr, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (spr_wn !== 1'b0 || spr_addr !== 16'h2004 || spr_wdata !== mem[16'h0200]) begin
            errors++; $display("FAIL basic_cycle2 wn=%b addr=%h wdata=%h exp=0/2004/%h", spr_wn, spr_addr, spr_wdata, mem[16'h0200]);
        end
        @(posedge clk); #1;
        run_xfer(3, 1'b0, 1'b0, 600, dc);
        checks++; if (dc != 513) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=513", dc); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_after_done busy=%b done=%b exp=0/0", busy, done); end
        build_exp(8'h02, 256);
        checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_seq[%0d] got=%h exp=%h", i, acc_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall;
        int dc;
        acc_q.delete();
        trigger_dma(8'h02);
        run_xfer(1, 1'b1, 1'b0, 4000, dc);
        checks++; if (dc == 0) begin errors++; $display("FAIL stall_timeout got=no_done exp=done"); end
        build_exp(8'h02, 256);
        checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_seq[%0d] got=%h exp=%h", i, acc_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_page_ff;
        int dc;
        acc_q.delete();
        trigger_dma(8'hFF);
        run_xfer(1, 1'b1, 1'b0, 4000, dc);
        checks++; if (dc == 0) begin errors++; $display("FAIL ff_timeout got=no_done exp=done"); end
        checks++; if (spr_req !== 1'b0 || spr_addr !== 16'h0000) begin errors++; $display("FAIL ff_after_done req=%b addr=%h exp=0/0000", spr_req, spr_addr); end
        build_exp(8'hFF, 256);
        checks++; if (acc_q.size() != 512) begin errors++; $display("FAIL ff_len got=%0d exp=512", acc_q.size()); end
        else begin
            checks++; if (acc_q[510].addr !== 16'hFFFF) begin errors++; $display("FAIL ff_last_read got=%h exp=FFFF", acc_q[510].addr); end
        end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL ff_seq[%0d] got=%h exp=%h", i, acc_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ignore_triggers;
        int dc;
        acc_q.delete();
        trigger_dma(8'h07);
        run_xfer(1, 1'b1, 1'b1, 4000, dc);
        checks++; if (dc == 0) begin errors++; $display("FAIL ignore_timeout got=no_done exp=done"); end
        build_exp(8'h07, 256);
        checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL ignore_len got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL ignore_seq[%0d] got=%h exp=%h", i, acc_q[i], exp_q[i]); end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_abort_restart;
        int dc;
        trigger_dma(8'h10);
        for (int c = 1; c <= 202; c++) begin
            gnt = 1'b1;
            @(negedge clk);
            if (c < 202) begin @(posedge clk); #1; end
        end
        checks++; if (spr_wn !== 1'b0 || spr_addr !== 16'h2004 || spr_wdata !== mem[16'h1064]) begin
            errors++; $display("FAIL abort_at_byte100 wn=%b addr=%h wdata=%h exp=0/2004/%h", spr_wn, spr_addr, spr_wdata, mem[16'h1064]);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (spr_req !== 1'b0 || spr_addr !== 16'h0000 || spr_wn !== 1'b1) begin
            errors++; $display("FAIL abort_async_bus req=%b addr=%h wn=%b exp=0/0000/1", spr_req, spr_addr, spr_wn);
        end
        checks++; if (spr_wdata !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_async_status wdata=%h busy=%b done=%b exp=00/0/0", spr_wdata, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        acc_q.delete();
        trigger_dma(8'h20);
        run_xfer(1, 1'b1, 1'b0, 4000, dc);
        checks++; if (dc == 0) begin errors++; $display("FAIL restart_timeout got=no_done exp=done"); end
        build_exp(8'h20, 256);
        checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL restart_len got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL restart_seq[%0d] got=%h exp=%h", i, acc_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_len4;
        int d4;
        int dc;
        d4 = 0;
        acc4_q.delete();
        trigger_dma(8'h03);
        for (int c = 1; c <= 20; c++) begin
            gnt = 1'b1;
            @(negedge clk);
            if (done4 && d4 == 0) d4 = c;
            @(posedge clk); #1;
        end
        checks++; if (d4 != 9) begin errors++; $display("FAIL len4_done_cycle got=%0d exp=9", d4); end
        build_exp(8'h03, 4);
        checks++; if (acc4_q.size() != exp_q.size()) begin errors++; $display("FAIL len4_len got=%0d exp=%0d", acc4_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < acc4_q.size(); i++) begin
            checks++; if (acc4_q[i] !== exp_q[i]) begin errors++; $display("FAIL len4_seq[%0d] got=%h exp=%h", i, acc4_q[i], exp_q[i]); end
        end
        // The full-length instance saw the same trigger; let it finish.
        run_xfer(21, 1'b0, 1'b0, 700, dc);
        checks++; if (dc != 513) begin errors++; $display("FAIL len4_main_done got=%0d exp=513", dc); end
    endtask

    initial begin
        rst = 1'b1; bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00; gnt = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_stall();
        test_page_ff();
        test_ignore_triggers();
        test_abort_restart();
        test_len4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
